// File: rtl/fft_pkg.sv
// Shared sample format, vector types and stage-0 FSM states for the 512-point,
// 16-lane parallel FFT datapath.
package fft_pkg;

  localparam int SIG        = 1;
  localparam int INT        = 2;
  localparam int FLT        = 6;
  localparam int WIDTH      = SIG + INT + FLT;
  localparam int LANES      = 16;
  localparam int HALF_BEATS = 16;
  localparam int FFT_N      = 512;
  localparam int CNT_W      = 5;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [0:LANES-1] cplx_vec_t;

  typedef enum logic {FILL, PAIR} state_t;

  localparam int VEC_W = $bits(cplx_vec_t);

endpackage

// File: rtl/fft_delay_line.sv
// Generic shift-register delay line: on each enabled cycle the head is loaded
// and every entry moves one place towards the tail.
module fft_delay_line #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 288
) (
  input  logic              clk,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tail
);

  // Contents are don't-care after reset, so no reset branch is needed.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign tail = mem[DEPTH-1];

endmodule

// File: rtl/fft_s0_delay_buf.sv
// Stage-0 input reorder: buffers the first half-frame and presents x[n+256]/x[n]
// pairs to the radix-2 butterfly with a contiguous 16-beat bfly_en window.
module fft_s0_delay_buf
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    din_valid,
  input  logic                    din_sop,
  input  logic signed [WIDTH-1:0] din_i   [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_q   [0:LANES-1],
  output logic signed [WIDTH-1:0] dout1_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout1_q [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_q [0:LANES-1],
  output logic                    bfly_en,
  output logic                    frame_err
);

  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(HALF_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(2 * HALF_BEATS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             pair_load, sop_restart, shift_en;
  cplx_vec_t        din_vec, tail_vec, dout1_r, dout2_r;
  logic [VEC_W-1:0] tail_flat;

  always_comb begin
    din_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      din_vec[k].re = din_i[k];
      din_vec[k].im = din_q[k];
    end
  end

  // A cleared beat is discarded entirely, so clr also blocks the shift.
  assign shift_en = din_valid & ~clr;

  fft_delay_line #(
    .DEPTH  (HALF_BEATS),
    .DATA_W (VEC_W)
  ) u_delay_line (
    .clk      (clk),
    .shift_en (shift_en),
    .din      (din_vec),
    .tail     (tail_flat)
  );

  assign tail_vec = tail_flat;

  // An early sop makes the current beat beat 0 of a new frame.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = beat_cnt;
    pair_load   = 1'b0;
    sop_restart = 1'b0;
    if (din_valid) begin
      if (din_sop && beat_cnt != '0) begin
        sop_restart = 1'b1;
        cnt_nxt     = CNT_W'(1);
        state_nxt   = FILL;
      end else begin
        cnt_nxt = beat_cnt + CNT_W'(1);
        unique case (state)
          FILL: if (beat_cnt == LAST_FILL) state_nxt = PAIR;
          PAIR: begin
            pair_load = 1'b1;
            if (beat_cnt == LAST_PAIR) state_nxt = FILL;
          end
          default: state_nxt = FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FILL;
      beat_cnt  <= '0;
      dout1_r   <= '0;
      dout2_r   <= '0;
      bfly_en   <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr) begin
      state     <= FILL;
      beat_cnt  <= '0;
      dout1_r   <= '0;
      dout2_r   <= '0;
      bfly_en   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      bfly_en  <= pair_load;
      if (pair_load) begin
        dout1_r <= din_vec;
        dout2_r <= tail_vec;
      end
      // The downstream twiddle counter cannot tolerate a broken window.
      if (sop_restart || (!din_valid && state == PAIR)) begin
        frame_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign dout1_i[k] = dout1_r[k].re;
    assign dout1_q[k] = dout1_r[k].im;
    assign dout2_i[k] = dout2_r[k].re;
    assign dout2_q[k] = dout2_r[k].im;
  end

endmodule

// File: tb/tb_fft_s0_delay_buf.sv
// Directed self-checking bench for fft_s0_delay_buf: ramp, signed extremes,
// back-to-back frames, gaps, early sop, clr and mid-frame reset.
module tb_fft_s0_delay_buf;

  logic              clk;
  logic              rstn;
  logic              clr;
  logic              din_valid;
  logic              din_sop;
  logic signed [8:0] din_i   [0:15];
  logic signed [8:0] din_q   [0:15];
  logic signed [8:0] dout1_i [0:15];
  logic signed [8:0] dout1_q [0:15];
  logic signed [8:0] dout2_i [0:15];
  logic signed [8:0] dout2_q [0:15];
  logic              bfly_en;
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  fft_s0_delay_buf dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .din_valid (din_valid),
    .din_sop   (din_sop),
    .din_i     (din_i),
    .din_q     (din_q),
    .dout1_i   (dout1_i),
    .dout1_q   (dout1_q),
    .dout2_i   (dout2_i),
    .dout2_q   (dout2_q),
    .bfly_en   (bfly_en),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rampVal(input int b, input int k);
    return (16 * b + k) % 256;
  endfunction

  task automatic setRamp(input int b);
    for (int k = 0; k < 16; k++) begin
      din_i[k] = 9'(rampVal(b, k));
      din_q[k] = 9'sd0;
    end
  endtask

  task automatic setConst(input int re, input int im);
    for (int k = 0; k < 16; k++) begin
      din_i[k] = 9'(re);
      din_q[k] = 9'(im);
    end
  endtask

  // Drive one cycle of stimulus and return 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic s);
    din_valid = v;
    din_sop   = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sop   = 1'b0;
  endtask

  task automatic applyClear(input logic v);
    clr       = 1'b1;
    din_valid = v;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    din_valid = 1'b0;
  endtask

  // Every lane of a PAIR beat b must carry ramp sample 16*(b-16)+k on both paths.
  task automatic checkRampPair(input string name, input int b);
    checkOutput($sformatf("%s b%0d en", name, b), bfly_en, 1);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("%s b%0d l%0d d2", name, b, k), dout2_i[k], rampVal(b - 16, k));
      checkOutput($sformatf("%s b%0d l%0d d1", name, b, k), dout1_i[k], rampVal(b - 16, k));
    end
  endtask

  task automatic runRampBeat(input string name, input int b, input logic s);
    setRamp(b);
    applyStimulus(1'b1, s);
    if (b >= 16) checkRampPair(name, b);
    else checkOutput($sformatf("%s b%0d en", name, b), bfly_en, 0);
  endtask

  initial begin
    int en_count;
    int rises;
    logic prev_en;

    rstn      = 1'b0;
    clr       = 1'b0;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    setConst(0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst en", bfly_en, 0);
    checkOutput("rst err", frame_err, 0);
    checkOutput("rst d1i", dout1_i[0], 0);
    checkOutput("rst d2q", dout2_q[15], 0);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0);

    $display("[TB] ramp frame");
    for (int b = 0; b < 32; b++) runRampBeat("ramp", b, b == 0);
    checkOutput("ramp err", frame_err, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ramp idle en", bfly_en, 0);

    $display("[TB] signed extremes");
    for (int b = 0; b < 32; b++) begin
      if (b < 16) setConst(-256, -256);
      else setConst(255, 255);
      applyStimulus(1'b1, b == 0);
      if (b >= 16) begin
        checkOutput($sformatf("ext b%0d en", b), bfly_en, 1);
        for (int k = 0; k < 16; k += 5) begin
          checkOutput($sformatf("ext b%0d l%0d d2i", b, k), dout2_i[k], -256);
          checkOutput($sformatf("ext b%0d l%0d d2q", b, k), dout2_q[k], -256);
          checkOutput($sformatf("ext b%0d l%0d d1i", b, k), dout1_i[k], 255);
          checkOutput($sformatf("ext b%0d l%0d d1q", b, k), dout1_q[k], 255);
        end
      end
    end
    checkOutput("ext err", frame_err, 0);

    $display("[TB] back-to-back frames");
    en_count = 0;
    rises    = 0;
    prev_en  = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 32; b++) begin
        if (b < 16) setConst(10 + 20 * f, 10 + 20 * f);
        else setConst(20 + 20 * f, 20 + 20 * f);
        applyStimulus(1'b1, b == 0);
        if (bfly_en) en_count++;
        if (bfly_en && !prev_en) rises++;
        prev_en = bfly_en;
        checkOutput($sformatf("b2b f%0d b%0d en", f, b), bfly_en, (b >= 16) ? 1 : 0);
        if (b >= 16) begin
          checkOutput($sformatf("b2b f%0d b%0d d1", f, b), dout1_i[15], 20 + 20 * f);
          checkOutput($sformatf("b2b f%0d b%0d d2", f, b), dout2_q[0], 10 + 20 * f);
        end
      end
    end
    checkOutput("b2b en count", en_count, 48);
    checkOutput("b2b windows", rises, 3);
    checkOutput("b2b err", frame_err, 0);

    $display("[TB] gap in fill");
    for (int b = 0; b < 32; b++) begin
      if (b == 5) begin
        setConst(99, 99);
        repeat (2) begin
          applyStimulus(1'b0, 1'b0);
          checkOutput("gapfill en", bfly_en, 0);
        end
      end
      runRampBeat("gapfill", b, b == 0);
    end
    checkOutput("gapfill err", frame_err, 0);

    $display("[TB] gap in pair");
    for (int b = 0; b < 32; b++) begin
      if (b == 20) begin
        setConst(99, 99);
        applyStimulus(1'b0, 1'b0);
        checkOutput("gappair en", bfly_en, 0);
        checkOutput("gappair err", frame_err, 1);
        checkOutput("gappair hold", dout2_i[3], rampVal(3, 3));
      end
      runRampBeat("gappair", b, b == 0);
    end
    checkOutput("gappair sticky", frame_err, 1);
    setRamp(7);
    applyClear(1'b1);
    checkOutput("clr err", frame_err, 0);
    checkOutput("clr en", bfly_en, 0);
    checkOutput("clr d1", dout1_i[4], 0);
    checkOutput("clr d2", dout2_i[9], 0);

    $display("[TB] early sop");
    for (int b = 0; b < 9; b++) begin
      setConst(100, 100);
      applyStimulus(1'b1, b == 0);
    end
    checkOutput("sop pre err", frame_err, 0);
    for (int b = 0; b < 32; b++) begin
      runRampBeat("sop", b, 1'b1 && b == 0);
      if (b == 0) checkOutput("sop err", frame_err, 1);
    end
    applyClear(1'b0);
    checkOutput("sop clr err", frame_err, 0);

    $display("[TB] reset mid-pair");
    for (int b = 0; b < 25; b++) runRampBeat("midrst", b, b == 0);
    rstn = 1'b0;
    #1;
    checkOutput("midrst en", bfly_en, 0);
    checkOutput("midrst d2", dout2_i[1], 0);
    checkOutput("midrst d1", dout1_i[5], 0);
    checkOutput("midrst err", frame_err, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int b = 0; b < 17; b++) runRampBeat("postrst", b, b == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_s0_delay_buf.md
Name: fft_s0_delay_buf

Overview:
- Input reorder/delay stage directly upstream of the stage-0 radix-2 butterfly in the 512-point, 16-lane parallel FFT datapath.
- Accepts 16 complex samples per cycle, so one frame is 32 beats.
- Holds the first half-frame (samples 0..255) in a 16-deep shift register.
- During the second half-frame (samples 256..511) it presents aligned pairs x[n+256] / x[n] to the butterfly, together with a contiguous bfly_en window.

Parameters:
- SIG, 1, sign bits of sample format
- INT, 2, integer bits
- FLT, 6, fractional bits
- WIDTH, SIG+INT+FLT, sample width (9)
- LANES, 16, parallel samples per beat
- HALF_BEATS, 16, beats per half-frame (256/LANES)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush: counter to 0, outputs to reset values, err cleared
- din_valid  in  1  input beat valid
- din_sop  in  1  first beat of frame, qualified by din_valid
- din_i  in  signed WIDTH x [0:15]  input real, lane k = sample 16*beat+k
- din_q  in  signed WIDTH x [0:15]  input imag
- dout1_i  out  signed WIDTH x [0:15]  direct path, x[n+256] real
- dout1_q  out  signed WIDTH x [0:15]  direct path imag
- dout2_i  out  signed WIDTH x [0:15]  delayed path, x[n] real
- dout2_q  out  signed WIDTH x [0:15]  delayed path imag
- bfly_en  out  1  pair valid, high for 16 consecutive cycles per frame
- frame_err  out  1  sticky alignment/gap error

Behaviour:
- Reset (rstn low, async) or clr (sync): beat_cnt=0, state=FILL, all dout*=0, bfly_en=0, frame_err=0. Shift register contents are don't-care and need not be reset.
- beat_cnt is 5 bits and advances only on din_valid. It wraps 31->0; wrap is the start of the next frame.
- Shift register: 16 entries of LANES complex words. On every din_valid beat it shifts by one and loads din at the head. Tail = the word loaded 16 valid beats earlier.
- FILL state (beat_cnt 0..15): data is only shifted in. Outputs hold their last values; bfly_en=0 next cycle.
- On the valid beat with beat_cnt==15, the state moves to PAIR.
- PAIR state (beat_cnt 16..31), on a valid beat, registered with 1-cycle latency:
  - dout1 <= din
  - dout2 <= tail
  - bfly_en <= 1
  - The shift still occurs.
  - On the valid beat with beat_cnt==31, the state returns to FILL.
- Lane pairing: dout1 lane k at PAIR beat b = sample 256+16*(b-16)+k; dout2 same lane = sample 16*(b-16)+k.
- Gap (din_valid=0):
  - No shift, no count, bfly_en <= 0, outputs hold.
  - A gap while in PAIR sets frame_err. The downstream twiddle counter requires a contiguous 16-cycle bfly_en window.
- din_sop handling:
  - din_sop with din_valid while beat_cnt!=0: frame_err=1, beat_cnt restarts so this beat is beat 0, state=FILL, bfly_en <= 0.
  - din_sop at beat_cnt==0 is normal.
  - Missing din_sop at beat 0 is tolerated, with no error.
- Back-to-back frames with continuous din_valid: the next frame's FILL beats overwrite the consumed entries. Output is 16 bfly_en cycles, then 16 idle, repeating with no bubble.
- clr and din_valid in the same cycle: clr wins and the beat is discarded.
- No arithmetic is performed. Widths pass through unchanged; growth happens in the butterfly.

Decomposition:
- Package fft_pkg holds:
  - sample params SIG/INT/FLT/WIDTH, LANES, HALF_BEATS, FFT_N=512
  - typedef cplx_t {re, im} of signed WIDTH
  - typedef cplx_vec_t = cplx_t [0:LANES-1]
  - enum state_t {FILL, PAIR}
- One sub-module: fft_delay_line (parameterised depth/width, shift-enable, tail output).

Test Plan:
- Ramp frame: din lane k at beat b = (16b+k) mod 256 in real, 0 in imag, with continuous valid and sop at beat 0 -> bfly_en high on cycles 17..32 after the first beat. dout2_i lane k = 16(b-16)+k mod 256 and dout1_i equals the same value, since 256 wraps to 0.
- Signed extremes: first half all -256, second half all +255 -> every paired beat has dout2=-256 and dout1=+255, in both i and q.
- Three back-to-back frames with distinct constants 10/20, 30/40, 50/60 -> exactly 48 bfly_en cycles in three 16-cycle windows, pairs (20,10), (40,30), (60,50), frame_err=0.
- din_valid dropped for 2 cycles at beat 5 (FILL) -> pairing still correct, window delayed by 2, frame_err=0. Drop 1 cycle at beat 20 -> bfly_en low for 1 cycle, frame_err=1 until clr.
- din_sop at beat 9 -> frame_err=1, new frame pairs correctly relative to the new sop.
- rstn asserted mid-PAIR at beat 24 -> all outputs 0 immediately. After release, no bfly_en until 16 valid beats following a fresh frame.
